sseg_scan_decoder: RTL and testbench

SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

---
 rtl/sseg_pkg.sv | 103 ++++++++++
 rtl/sseg_pattern_decode.sv | 17 +
 rtl/sseg_scan_decoder.sv | 156 +++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: active-low {g..a} glyph patterns,
// scan decoder state encoding and pattern/anode helper functions.
package sseg_pkg;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   typedef enum logic [1:0] {
      ST_WAIT     = 2'd0,
      ST_SETTLING = 2'd1,
      ST_HOLD     = 2'd2
   } scan_state_t;

   typedef struct packed {
      logic       ok;
      logic [3:0] nib;
   } seg_dec_t;

   function automatic seg_dec_t seg_decode(input logic [6:0] pat);
      seg_dec_t d;
      d.ok  = 1'b1;
      d.nib = 4'h0;
      case (pat)
         SEG_0:   d.nib = 4'h0;
         SEG_1:   d.nib = 4'h1;
         SEG_2:   d.nib = 4'h2;
         SEG_3:   d.nib = 4'h3;
         SEG_4:   d.nib = 4'h4;
         SEG_5:   d.nib = 4'h5;
         SEG_6:   d.nib = 4'h6;
         SEG_7:   d.nib = 4'h7;
         SEG_8:   d.nib = 4'h8;
         SEG_9:   d.nib = 4'h9;
         SEG_A:   d.nib = 4'hA;
         SEG_B:   d.nib = 4'hB;
         SEG_C:   d.nib = 4'hC;
         SEG_D:   d.nib = 4'hD;
         SEG_E:   d.nib = 4'hE;
         SEG_F:   d.nib = 4'hF;
         default: d.ok  = 1'b0;
      endcase
      return d;
   endfunction

   // Inverse mapping for the display driver side.
   function automatic logic [6:0] seg_encode(input logic [3:0] nib);
      logic [6:0] p;
      case (nib)
         4'h0: p = SEG_0;
         4'h1: p = SEG_1;
         4'h2: p = SEG_2;
         4'h3: p = SEG_3;
         4'h4: p = SEG_4;
         4'h5: p = SEG_5;
         4'h6: p = SEG_6;
         4'h7: p = SEG_7;
         4'h8: p = SEG_8;
         4'h9: p = SEG_9;
         4'hA: p = SEG_A;
         4'hB: p = SEG_B;
         4'hC: p = SEG_C;
         4'hD: p = SEG_D;
         4'hE: p = SEG_E;
         default: p = SEG_F;
      endcase
      return p;
   endfunction

   function automatic logic an_onehot_low(input logic [3:0] an);
      logic r;
      case (an)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] an_slot(input logic [3:0] an);
      logic [1:0] s;
      case (an)
         4'b1101: s = 2'd1;
         4'b1011: s = 2'd2;
         4'b0111: s = 2'd3;
         default: s = 2'd0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational seven-segment pattern to hex nibble decode with a
// flag for patterns that are not one of the sixteen hex glyphs.
module sseg_pattern_decode
   import sseg_pkg::*;
(
   input  logic [6:0] pat,
   output logic [3:0] nib,
   output logic       ok
);

   seg_dec_t dec;

   assign dec = seg_decode(pat);
   assign nib = dec.nib;
   assign ok  = dec.ok;

endmodule

// File: rtl/sseg_scan_decoder.sv
// Recovers a 16-bit hex word by watching a multiplexed, active-low
// four-digit seven-segment display bus (anodes + segments).
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_WAIT     | anodes not exactly one-low, nothing to sample
// ST_SETTLING | one digit active, counting stable cycles before sampling
// ST_HOLD     | digit sampled, waiting for the anodes to move on
module sseg_scan_decoder
   import sseg_pkg::*;
#(
   parameter int unsigned SETTLE        = 4,
   parameter int unsigned FRAME_TIMEOUT = 400000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  an,
   input  logic [6:0]  sseg,
   output logic [15:0] value,
   output logic        valid,
   output logic        seg_err,
   output logic        timeout,
   output logic [3:0]  digit_mask
);

   localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [23:0] FRAME_LAST  = 24'(FRAME_TIMEOUT - 1);

   scan_state_t state, state_nxt;

   logic [3:0]  an_q, an_p;
   logic [6:0]  sseg_q, sseg_p;
   logic [7:0]  settle_cnt;
   logic [23:0] frame_cnt;
   logic [15:0] frame_buf;

   logic       onehot, an_changed, changed;
   logic       cnt_load, cnt_inc, sample;
   logic [3:0] dec_nib;
   logic       dec_ok;
   logic       sample_ok, frame_done, frame_expire;
   logic [1:0] slot;

   // Two register stages: the first is the only synchroniser on the
   // external bus, the second gives the previous cycle for change detect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_q   <= 4'hF;
         an_p   <= 4'hF;
         sseg_q <= 7'h7F;
         sseg_p <= 7'h7F;
      end else begin
         an_q   <= an;
         an_p   <= an_q;
         sseg_q <= sseg;
         sseg_p <= sseg_q;
      end
   end

   assign onehot     = an_onehot_low(an_q);
   assign an_changed = (an_q != an_p);
   assign changed    = an_changed || (sseg_q != sseg_p);
   assign slot       = an_slot(an_q);

   sseg_pattern_decode u_decode (
      .pat (sseg_q),
      .nib (dec_nib),
      .ok  (dec_ok)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_WAIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_WAIT: begin
            if (onehot) state_nxt = ST_SETTLING;
         end
         ST_SETTLING: begin
            if (!onehot)                         state_nxt = ST_WAIT;
            else if (!changed && settle_cnt == SETTLE_LAST) state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (an_changed) state_nxt = onehot ? ST_SETTLING : ST_WAIT;
         end
         default: state_nxt = ST_WAIT;
      endcase
   end

   always_comb begin
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      sample   = 1'b0;
      case (state)
         ST_WAIT:     cnt_load = onehot;
         ST_SETTLING: begin
            if (onehot) begin
               if (changed)                         cnt_load = 1'b1;
               else if (settle_cnt == SETTLE_LAST)  sample   = 1'b1;
               else                                 cnt_inc  = 1'b1;
            end
         end
         ST_HOLD:     cnt_load = an_changed && onehot;
         default:     ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         settle_cnt <= 8'd0;
      else if (cnt_load) settle_cnt <= 8'd0;
      else if (cnt_inc)  settle_cnt <= settle_cnt + 8'd1;
   end

   assign sample_ok    = sample && dec_ok;
   assign frame_done   = (digit_mask == 4'hF);
   assign frame_expire = (digit_mask != 4'h0) && (frame_cnt == FRAME_LAST);

   // A full mask is shown for one cycle, then published and cleared;
   // no sample can land in that cycle because the FSM is in HOLD.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_buf  <= 16'h0000;
         digit_mask <= 4'h0;
         frame_cnt  <= 24'd0;
         value      <= 16'h0000;
         valid      <= 1'b0;
         seg_err    <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         valid   <= 1'b0;
         timeout <= 1'b0;
         seg_err <= sample && !dec_ok;

         if (digit_mask == 4'h0 || frame_done || frame_expire)
            frame_cnt <= 24'd0;
         else
            frame_cnt <= frame_cnt + 24'd1;

         if (frame_done) begin
            value      <= frame_buf;
            valid      <= 1'b1;
            digit_mask <= 4'h0;
         end else if (sample_ok) begin
            frame_buf[{slot, 2'b00} +: 4] <= dec_nib;
            digit_mask[slot]              <= 1'b1;
         end else if (frame_expire) begin
            digit_mask <= 4'h0;
            timeout    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Scoreboard bench for sseg_scan_decoder: stimulus pushes expected
// valid/seg_err/timeout events, a negedge monitor pops and compares them.
module tb_sseg_scan_decoder;

   localparam int SETTLE = 4;
   localparam int FTO    = 100;

   typedef enum logic [1:0] {EV_VALID, EV_SEGERR, EV_TIMEOUT} ev_kind_t;
   typedef struct packed {
      ev_kind_t    kind;
      logic [15:0] val;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  an;
   logic [6:0]  sseg;
   logic [15:0] value;
   logic        valid, seg_err, timeout;
   logic [3:0]  digit_mask;

   int  n_tests = 0;
   int  n_fail  = 0;
   ev_t exp_q[$];

   sseg_scan_decoder #(.SETTLE(SETTLE), .FRAME_TIMEOUT(FTO)) dut (
      .clk        (clk),
      .reset      (reset),
      .an         (an),
      .sseg       (sseg),
      .value      (value),
      .valid      (valid),
      .seg_err    (seg_err),
      .timeout    (timeout),
      .digit_mask (digit_mask)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_ev(input ev_kind_t k, input logic [15:0] v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic handle(input ev_kind_t k);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d value %0h, expected none", k, value);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 32'(k), 32'(e.kind));
         if (k == EV_VALID || k == EV_TIMEOUT) check("event_value", 32'(value), 32'(e.val));
         if (k == EV_TIMEOUT) check("timeout_mask", 32'(digit_mask), 32'h0);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (valid   === 1'b1) handle(EV_VALID);
            if (seg_err === 1'b1) handle(EV_SEGERR);
            if (timeout === 1'b1) handle(EV_TIMEOUT);
         end
      end
   end

   task automatic scan(input int k, input logic [6:0] pat, input int cyc);
      @(posedge clk); #1;
      an   = ~(4'b0001 << k);
      sseg = pat;
      repeat (cyc - 1) @(posedge clk);
   endtask

   task automatic idle(input int cyc);
      @(posedge clk); #1;
      an   = 4'hF;
      sseg = 7'h7F;
      repeat (cyc - 1) @(posedge clk);
   endtask

   // Counts cycles from the first nonzero digit_mask to the timeout pulse.
   task automatic measure_timeout(output int n);
      int i;
      i = 0;
      while (digit_mask == 4'h0 && i < 300) begin
         @(negedge clk);
         i++;
      end
      n = 0;
      while (timeout !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_to;
      reset = 1'b1;
      an    = 4'hF;
      sseg  = 7'h7F;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_value", 32'(value), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_seg_err", 32'(seg_err), 32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
      check("rst_mask", 32'(digit_mask), 32'h0);
      reset = 1'b0;
      idle(3);

      // Plain scan of 4,3,2,1
      expect_ev(EV_VALID, 16'h4321);
      scan(0, 7'h79, 20);
      scan(1, 7'h24, 20);
      scan(2, 7'h30, 20);
      scan(3, 7'h19, 20);
      idle(5);
      @(negedge clk);
      check("mask_after_frame", 32'(digit_mask), 32'h0);

      // Chattering digit then stable: exact settle latency
      @(posedge clk); #1;
      an = 4'b1110;
      for (int i = 0; i < 5; i++) begin
         sseg = (i % 2 == 1) ? 7'h24 : 7'h79;
         repeat (2) @(posedge clk);
         #1;
      end
      check("chatter_no_sample", 32'(digit_mask), 32'h0);
      sseg = 7'h30;
      for (int k = 1; k <= SETTLE + 2; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == SETTLE + 1) check("latency_early", 32'(digit_mask), 32'h0);
         if (k == SETTLE + 2) check("latency_exact", 32'(digit_mask), 32'h1);
      end
      expect_ev(EV_VALID, 16'h7653);
      repeat (12) @(posedge clk);
      scan(1, 7'h12, 20);
      scan(2, 7'h02, 20);
      scan(3, 7'h78, 20);
      idle(5);

      // Invalid glyph on digit 2, then abandoned frame times out
      expect_ev(EV_SEGERR, 16'h0000);
      expect_ev(EV_TIMEOUT, 16'h7653);
      scan(0, 7'h79, 20);
      scan(1, 7'h24, 20);
      scan(2, 7'h7F, 20);
      scan(3, 7'h30, 20);
      @(negedge clk);
      check("segerr_mask", 32'(digit_mask), 32'hB);
      idle(60);

      // Three digits then idle: timeout exactly FTO cycles after first capture
      expect_ev(EV_TIMEOUT, 16'h7653);
      fork
         begin
            scan(0, 7'h10, 20);
            scan(1, 7'h08, 20);
            scan(2, 7'h03, 20);
            idle(80);
         end
         measure_timeout(n_to);
      join
      check("timeout_cycles", 32'(n_to), 32'(FTO));
      check("timeout_value_kept", 32'(value), 32'h7653);

      // Reset mid-frame of FFFF, then a fresh 0001 frame
      scan(0, 7'h0E, 20);
      scan(1, 7'h0E, 20);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("midrst_value", 32'(value), 32'h0);
      check("midrst_mask", 32'(digit_mask), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(3);
      expect_ev(EV_VALID, 16'h0001);
      scan(0, 7'h79, 20);
      scan(1, 7'h40, 20);
      scan(2, 7'h40, 20);
      scan(3, 7'h40, 20);
      idle(5);

      // Digit 0 captured twice: later nibble wins
      expect_ev(EV_VALID, 16'h0008);
      scan(0, 7'h30, 20);
      idle(5);
      scan(0, 7'h00, 20);
      scan(1, 7'h40, 20);
      scan(2, 7'h40, 20);
      scan(3, 7'h40, 20);
      idle(20);

      @(negedge clk);
      check("value_final", 32'(value), 32'h0008);
      check("events_pending", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
